// File: rtl/bsg_rr_burst_arb_pkg.sv
// rtl/bsg_rr_burst_arb_pkg.sv - shared types and width helper for the burst arbiter
package bsg_rr_burst_arb_pkg;

  typedef enum logic {eIdle, eLock} bsg_rr_burst_arb_state_e;

  // Field width that never collapses to zero bits for degenerate sizes
  function automatic int bsg_rr_burst_arb_lg(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_rr_burst_arb_pick.sv
// rtl/bsg_rr_burst_arb_pick.sv - combinational round-robin picker
// Rotates requests to start after last, priority-encodes, rotates the index back.
module bsg_rr_burst_arb_pick
  import bsg_rr_burst_arb_pkg::*;
#(
  parameter int inputs_p = 4,
  localparam int lg_inputs_lp = bsg_rr_burst_arb_lg(inputs_p)
) (
  input  logic [inputs_p-1:0]     reqs,
  input  logic [lg_inputs_lp-1:0] last,
  output logic [inputs_p-1:0]     grant,
  output logic [lg_inputs_lp-1:0] tag
);

  localparam logic [lg_inputs_lp:0] n_lp = (lg_inputs_lp+1)'(inputs_p);

  logic [lg_inputs_lp:0]   start;
  logic [lg_inputs_lp:0]   sum;
  logic [lg_inputs_lp-1:0] enc;
  logic [2*inputs_p-1:0]   doubled;
  logic [inputs_p-1:0]     rotated;

  always_comb begin
    start = {1'b0, last} + 1'b1;
    if (start >= n_lp) start = '0;
    doubled = {reqs, reqs};
    rotated = doubled[start +: inputs_p];
    enc = '0;
    for (int i = inputs_p - 1; i >= 0; i--) begin
      if (rotated[i]) enc = lg_inputs_lp'(i);
    end
    sum = start + {1'b0, enc};
    if (sum >= n_lp) sum = sum - n_lp;
    tag   = '0;
    grant = '0;
    if (|reqs) begin
      tag        = sum[lg_inputs_lp-1:0];
      grant[tag] = 1'b1;
    end
  end

endmodule

// File: rtl/bsg_rr_burst_arb.sv
// rtl/bsg_rr_burst_arb.sv - round-robin arbiter that locks the grant for a whole burst
// Define BSG_RR_BURST_ARB_ASSERT_EN to compile in simulation checks.
module bsg_rr_burst_arb
  import bsg_rr_burst_arb_pkg::*;
#(
  parameter int inputs_p    = 4,
  parameter int max_burst_p = 4,
  localparam int lg_burst_lp  = bsg_rr_burst_arb_lg(max_burst_p),
  localparam int lg_inputs_lp = bsg_rr_burst_arb_lg(inputs_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            grants_en_i,
  input  logic [inputs_p-1:0]             reqs_i,
  input  logic [inputs_p*lg_burst_lp-1:0] len_i,
  output logic [inputs_p-1:0]             grants_o,
  output logic [lg_inputs_lp-1:0]         tag_o,
  output logic                            v_o,
  input  logic                            yumi_i
);

  localparam logic [lg_inputs_lp-1:0] last_init_lp = lg_inputs_lp'(inputs_p - 1);
  localparam logic [lg_burst_lp-1:0]  one_beat_lp  = lg_burst_lp'(1);

  bsg_rr_burst_arb_state_e state_r, state_n;
  logic [lg_inputs_lp-1:0] last_r, last_n;
  logic [lg_inputs_lp-1:0] owner_r, owner_n;
  logic [lg_burst_lp-1:0]  beats_r, beats_n;
  logic [inputs_p-1:0]     pick_grant;
  logic [lg_inputs_lp-1:0] pick_tag;
  logic [lg_burst_lp-1:0]  win_len;
  logic                    fire;

  bsg_rr_burst_arb_pick #(
    .inputs_p(inputs_p)
  ) pick (
    .reqs (reqs_i),
    .last (last_r),
    .grant(pick_grant),
    .tag  (pick_tag)
  );

  always_comb begin
    win_len = '0;
    for (int i = 0; i < inputs_p; i++) begin
      if (pick_tag == lg_inputs_lp'(i)) win_len = len_i[i*lg_burst_lp +: lg_burst_lp];
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock
  always_comb begin
    grants_o = '0;
    tag_o    = '0;
    v_o      = 1'b0;
    state_n  = state_r;
    last_n   = last_r;
    owner_n  = owner_r;
    beats_n  = beats_r;
    if (reset_n_i) begin
      case (state_r)
        eIdle: begin
          grants_o = pick_grant;
          tag_o    = pick_tag;
          v_o      = (|reqs_i) & grants_en_i;
        end
        eLock: begin
          grants_o[owner_r] = 1'b1;
          tag_o             = owner_r;
          v_o               = reqs_i[owner_r] & grants_en_i;
        end
      endcase
    end
    fire = yumi_i & v_o;
    if (fire) begin
      case (state_r)
        eIdle: begin
          if (win_len == '0) begin
            last_n = pick_tag;
          end else begin
            owner_n = pick_tag;
            beats_n = win_len;
            state_n = eLock;
          end
        end
        eLock: begin
          beats_n = beats_r - one_beat_lp;
          if (beats_r == one_beat_lp) begin
            last_n  = owner_r;
            state_n = eIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIdle;
      last_r  <= last_init_lp;
      owner_r <= '0;
      beats_r <= '0;
    end else begin
      state_r <= state_n;
      last_r  <= last_n;
      owner_r <= owner_n;
      beats_r <= beats_n;
    end
  end

`ifdef BSG_RR_BURST_ARB_ASSERT_EN
  localparam logic [lg_burst_lp-1:0] max_len_lp = lg_burst_lp'(max_burst_p - 1);

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (yumi_i && !v_o) $error("bsg_rr_burst_arb: yumi_i without v_o");
      if (state_r == eLock && !reqs_i[owner_r]) $error("bsg_rr_burst_arb: owner request dropped mid-burst");
      if (state_r == eIdle && fire && win_len > max_len_lp) $error("bsg_rr_burst_arb: len_i above max_burst_p-1");
      if (!$onehot0(grants_o)) $error("bsg_rr_burst_arb: grants_o not one-hot");
    end
  end
`else
  // checks compiled out; datapath above is unchanged
`endif

endmodule
